sprite_position_table: RTL and testbench

- Parametrised successor to the single 32-bit position export: holds X/Y positions for N_SPRITES sprites (Pac-Man, ghosts, fruit) behind an Avalon-MM-style slave.
- CPU writes land in a shadow bank. A commit copies the shadow bank to the active bank on the next refresh_image rising edge (frame boundary), so the renderer never sees a half-updated frame.
- Sits between the Nios/Qsys bus and the HDMI sprite renderer.

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/frame_tick_sync.sv | 25 ++
 rtl/sprite_position_table.sv | 131 +++++++++++++
 tb/tb_sprite_position_table.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared register-map offsets, CTRL bit indices, field positions and the
// coordinate clamp used by the sprite position table.
package sprite_pkg;

   // CTRL and STATUS sit immediately after the POS[] block.
   localparam int CTRL_OFS      = 0;
   localparam int STATUS_OFS    = 1;

   localparam int COMMIT_BIT    = 0;
   localparam int IMMEDIATE_BIT = 1;

   localparam int X_LSB         = 0;
   localparam int Y_LSB         = 16;
   localparam int FRAME_CNT_LSB = 16;

   function automatic logic [15:0] clamp_coord(input logic [15:0] value,
                                                input logic [15:0] limit);
      return (value >= limit) ? (limit - 16'd1) : value;
   endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Two-flop synchroniser for the asynchronous frame strobe followed by a
// rising-edge detector; tick is high for exactly one clk cycle per edge.
module frame_tick_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic tick
);

   logic [1:0] sync_reg;
   logic       prev_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg <= 2'b00;
         prev_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[0], async_in};
         prev_reg <= sync_reg[1];
      end
   end

   assign tick = sync_reg[1] & ~prev_reg;

endmodule

// File: rtl/sprite_position_table.sv
// Double-banked sprite X/Y table: CPU writes go to the shadow bank, which is
// copied to the active (renderer-facing) bank on the first frame tick after a commit.
module sprite_position_table
   import sprite_pkg::*;
#(
   parameter int N_SPRITES = 8,
   parameter int COORD_W   = 10,
   parameter int X_MAX     = 640,
   parameter int Y_MAX     = 480,
   parameter int ADDR_W    = 4
) (
   input  logic                             clk_clk,
   input  logic                             reset_reset,
   input  logic [ADDR_W-1:0]                avs_address,
   input  logic                             avs_write,
   input  logic [31:0]                      avs_writedata,
   input  logic                             avs_read,
   output logic [31:0]                      avs_readdata,
   input  logic                             refresh_image_export,
   output logic [N_SPRITES*2*COORD_W-1:0]   position_table_export,
   output logic                             commit_done_export
);

   localparam int ENTRY_W = 2 * COORD_W;
   localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(N_SPRITES + CTRL_OFS);
   localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(N_SPRITES + STATUS_OFS);

   logic                           tick;
   logic                           pending_reg;
   logic                           immediate_reg;
   logic                           commit_done_reg;
   logic [15:0]                    frame_count_reg;
   logic [31:0]                    readdata_reg;
   logic [31:0]                    readdata_next;
   logic [N_SPRITES*ENTRY_W-1:0]   shadow_flat;
   logic [15:0]                    x_clamped;
   logic [15:0]                    y_clamped;
   logic [ENTRY_W-1:0]             wr_entry;
   logic                           ctrl_write;
   logic                           commit_write;
   logic                           swap;
   logic                           unused_bits;

   frame_tick_sync u_frame_tick_sync (
      .clk      (clk_clk),
      .rst      (reset_reset),
      .async_in (refresh_image_export),
      .tick     (tick)
   );

   assign x_clamped   = clamp_coord(16'(avs_writedata[X_LSB +: COORD_W]), 16'(X_MAX));
   assign y_clamped   = clamp_coord(16'(avs_writedata[Y_LSB +: COORD_W]), 16'(Y_MAX));
   assign wr_entry    = {y_clamped[COORD_W-1:0], x_clamped[COORD_W-1:0]};
   assign unused_bits = ^{avs_writedata, x_clamped, y_clamped};

   assign ctrl_write   = avs_write && (avs_address == CTRL_ADDR);
   assign commit_write = ctrl_write && avs_writedata[COMMIT_BIT];
   // A commit arriving on the tick itself defers to the next frame.
   assign swap         = tick && pending_reg && !commit_write;

   genvar gi;
   generate
      for (gi = 0; gi < N_SPRITES; gi++) begin : g_chan
         logic [ENTRY_W-1:0] shadow_reg;
         logic [ENTRY_W-1:0] active_reg;
         logic               pos_write;

         assign pos_write = avs_write && (avs_address == ADDR_W'(gi));

         // The swap copies the pre-write shadow; an immediate write wins over it.
         always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
               shadow_reg <= '0;
               active_reg <= '0;
            end else begin
               if (pos_write)
                  shadow_reg <= wr_entry;
               if (pos_write && immediate_reg)
                  active_reg <= wr_entry;
               else if (swap)
                  active_reg <= shadow_reg;
            end
         end

         assign shadow_flat[gi*ENTRY_W +: ENTRY_W]           = shadow_reg;
         assign position_table_export[gi*ENTRY_W +: ENTRY_W] = active_reg;
      end
   endgenerate

   always_comb begin
      readdata_next = '0;
      for (int i = 0; i < N_SPRITES; i++) begin
         if (32'(avs_address) == i) begin
            readdata_next[X_LSB +: COORD_W] = shadow_flat[i*ENTRY_W +: COORD_W];
            readdata_next[Y_LSB +: COORD_W] = shadow_flat[i*ENTRY_W+COORD_W +: COORD_W];
         end
      end
      if (avs_address == CTRL_ADDR)
         readdata_next[IMMEDIATE_BIT] = immediate_reg;
      if (avs_address == STATUS_ADDR) begin
         readdata_next[0]                  = pending_reg;
         readdata_next[FRAME_CNT_LSB +: 16] = frame_count_reg;
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         pending_reg     <= 1'b0;
         immediate_reg   <= 1'b0;
         commit_done_reg <= 1'b0;
         frame_count_reg <= 16'd0;
         readdata_reg    <= 32'd0;
      end else begin
         commit_done_reg <= swap;
         if (tick)
            frame_count_reg <= frame_count_reg + 16'd1;
         if (commit_write)
            pending_reg <= 1'b1;
         else if (swap)
            pending_reg <= 1'b0;
         if (ctrl_write)
            immediate_reg <= avs_writedata[IMMEDIATE_BIT];
         if (avs_read)
            readdata_reg <= readdata_next;
      end
   end

   assign avs_readdata       = readdata_reg;
   assign commit_done_export = commit_done_reg;

endmodule

// File: tb/tb_sprite_position_table.sv
// Directed self-checking bench for sprite_position_table (default parameters).
module tb_sprite_position_table;

   localparam int N  = 8;
   localparam int CW = 10;
   localparam int EW = 2 * CW;
   localparam logic [3:0] A_CTRL   = 4'd8;
   localparam logic [3:0] A_STATUS = 4'd9;

   logic              clk_clk;
   logic              reset_reset;
   logic [3:0]        avs_address;
   logic              avs_write;
   logic [31:0]       avs_writedata;
   logic              avs_read;
   logic [31:0]       avs_readdata;
   logic              refresh_image_export;
   logic [N*EW-1:0]   position_table_export;
   logic              commit_done_export;

   int checks = 0;
   int errors = 0;

   sprite_position_table dut (
      .clk_clk               (clk_clk),
      .reset_reset           (reset_reset),
      .avs_address           (avs_address),
      .avs_write             (avs_write),
      .avs_writedata         (avs_writedata),
      .avs_read              (avs_read),
      .avs_readdata          (avs_readdata),
      .refresh_image_export  (refresh_image_export),
      .position_table_export (position_table_export),
      .commit_done_export    (commit_done_export)
   );

   initial clk_clk = 1'b0;
   always #5 clk_clk = ~clk_clk;

   function automatic logic [EW-1:0] field(input int i);
      return position_table_export[i*EW +: EW];
   endfunction

   task automatic wr(input logic [3:0] addr, input logic [31:0] data);
      avs_address   = addr;
      avs_writedata = data;
      avs_write     = 1'b1;
      @(posedge clk_clk); #1;
      avs_write     = 1'b0;
      $display("write addr=%0d data=%08h", addr, data);
   endtask

   task automatic rd(input logic [3:0] addr, output logic [31:0] data);
      avs_address = addr;
      avs_read    = 1'b1;
      @(posedge clk_clk); #1;
      avs_read    = 1'b0;
      data        = avs_readdata;
      $display("read  addr=%0d data=%08h", addr, data);
   endtask

   task automatic pulse_refresh();
      refresh_image_export = 1'b1;
      repeat (4) begin @(posedge clk_clk); #1; end
      refresh_image_export = 1'b0;
      repeat (4) begin @(posedge clk_clk); #1; end
      $display("refresh pulse");
   endtask

   task automatic apply_reset();
      reset_reset = 1'b1;
      @(posedge clk_clk); #1;
      reset_reset = 1'b0;
      @(posedge clk_clk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset_reset = 1'b1;
      @(posedge clk_clk); #1;
      checks++;
      if (position_table_export !== '0) begin
         errors++; $display("FAIL reset_export: got %h expected 0", position_table_export);
      end
      checks++;
      if (avs_readdata !== 32'd0 || commit_done_export !== 1'b0) begin
         errors++; $display("FAIL reset_outputs: readdata %h commit %b expected 0/0", avs_readdata, commit_done_export);
      end
      reset_reset = 1'b0;
      @(posedge clk_clk); #1;
      rd(A_STATUS, d);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL reset_status: got %08h expected 00000000", d); end
      wr(4'd15, 32'hFFFF_FFFF);
      rd(4'd15, d);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL unmapped_read: got %08h expected 00000000", d); end
   endtask

   task automatic test_commit();
      logic [31:0] d;
      int first_seen = 0;
      int pulses = 0;
      wr(4'd2, 32'h0064_00C8);
      wr(A_CTRL, 32'h1);
      refresh_image_export = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk_clk); #1;
         if (c == 4) refresh_image_export = 1'b0;
         if (commit_done_export) pulses++;
         if (first_seen == 0 && field(2) === EW'((100 << 10) | 200)) first_seen = c;
      end
      checks++;
      if (first_seen < 1 || first_seen > 3) begin
         errors++; $display("FAIL commit_latency: seen at cycle %0d field %h expected cycle 1..3 field %h", first_seen, field(2), EW'((100 << 10) | 200));
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL commit_pulse: got %0d pulses expected 1", pulses); end
      rd(A_STATUS, d);
      checks++;
      if (d !== 32'h0001_0000) begin errors++; $display("FAIL commit_status: got %08h expected 00010000", d); end
      rd(4'd2, d);
      checks++;
      if (d !== 32'h0064_00C8) begin errors++; $display("FAIL pos2_readback: got %08h expected 006400c8", d); end
   endtask

   task automatic test_no_commit();
      logic [31:0] d;
      apply_reset();
      wr(4'd0, 32'h0000_0010);
      pulse_refresh();
      checks++;
      if (field(0) !== '0) begin errors++; $display("FAIL no_commit_active: got %h expected 0", field(0)); end
      rd(A_STATUS, d);
      checks++;
      if (d !== 32'h0001_0000) begin errors++; $display("FAIL no_commit_status: got %08h expected 00010000", d); end
   endtask

   task automatic test_clamp();
      logic [31:0] d;
      logic [31:0] held;
      logic [31:0] vin  [4] = '{32'h03FF_03FF, 32'h01DF_0280, 32'h01E0_027F, 32'hFC00_FC05};
      logic [31:0] vexp [4] = '{32'h01DF_027F, 32'h01DF_027F, 32'h01DF_027F, 32'h0000_0005};
      for (int k = 0; k < 4; k++) begin
         wr(4'd4, vin[k]);
         rd(4'd4, d);
         checks++;
         if (d !== vexp[k]) begin errors++; $display("FAIL clamp_%0d: got %08h expected %08h", k, d, vexp[k]); end
      end
      wr(4'd6, 32'h01DE_027F);
      rd(4'd6, d);
      checks++;
      if (d !== 32'h01DE_027F) begin errors++; $display("FAIL clamp_in_range: got %08h expected 01de027f", d); end
      held = d;
      repeat (2) begin @(posedge clk_clk); #1; end
      checks++;
      if (avs_readdata !== held) begin errors++; $display("FAIL readdata_hold: got %08h expected %08h", avs_readdata, held); end
      wr(4'd1, 32'h03FF_03FF);
      rd(4'd1, d);
      checks++;
      if (d !== 32'h01DF_027F) begin errors++; $display("FAIL clamp_pos1: got %08h expected 01df027f", d); end
      wr(A_CTRL, 32'h1);
      pulse_refresh();
      checks++;
      if (field(1) !== EW'((479 << 10) | 639)) begin
         errors++; $display("FAIL clamp_export: got %h expected %h", field(1), EW'((479 << 10) | 639));
      end
   endtask

   task automatic test_immediate();
      logic [31:0] d;
      wr(A_CTRL, 32'h2);
      rd(A_CTRL, d);
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL ctrl_readback: got %08h expected 00000002", d); end
      wr(4'd3, 32'h0005_0006);
      checks++;
      if (field(3) !== EW'((5 << 10) | 6)) begin
         errors++; $display("FAIL immediate_export: got %h expected %h", field(3), EW'((5 << 10) | 6));
      end
      checks++;
      if (commit_done_export !== 1'b0) begin errors++; $display("FAIL immediate_no_pulse: got %b expected 0", commit_done_export); end
   endtask

   task automatic test_commit_on_tick();
      logic [31:0] d;
      int pulses = 0;
      wr(A_CTRL, 32'h0);
      wr(4'd5, 32'h0007_0008);
      refresh_image_export = 1'b1;
      @(posedge clk_clk); #1;
      @(posedge clk_clk); #1;
      // the synchronised edge is now in its tick cycle; land the commit on it
      avs_address   = A_CTRL;
      avs_writedata = 32'h1;
      avs_write     = 1'b1;
      @(posedge clk_clk); #1;
      avs_write     = 1'b0;
      $display("write addr=%0d data=%08h (on tick)", A_CTRL, 32'h1);
      for (int c = 0; c < 5; c++) begin
         if (c == 1) refresh_image_export = 1'b0;
         if (commit_done_export) pulses++;
         @(posedge clk_clk); #1;
      end
      checks++;
      if (field(5) !== '0 || pulses != 0) begin
         errors++; $display("FAIL tick_commit_noswap: field %h pulses %0d expected 0/0", field(5), pulses);
      end
      rd(A_STATUS, d);
      checks++;
      if (d !== 32'h0003_0001) begin errors++; $display("FAIL tick_commit_pending: got %08h expected 00030001", d); end
      pulse_refresh();
      checks++;
      if (field(5) !== EW'((7 << 10) | 8)) begin
         errors++; $display("FAIL tick_commit_swap: got %h expected %h", field(5), EW'((7 << 10) | 8));
      end
      rd(A_STATUS, d);
      checks++;
      if (d !== 32'h0004_0000) begin errors++; $display("FAIL tick_commit_status: got %08h expected 00040000", d); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      rd(A_STATUS, d);
      #2;
      reset_reset = 1'b1;
      #1;
      checks++;
      if (position_table_export !== '0 || avs_readdata !== 32'd0) begin
         errors++; $display("FAIL async_reset: export %h readdata %08h expected 0/0", position_table_export, avs_readdata);
      end
      @(posedge clk_clk); #1;
      reset_reset = 1'b0;
      rd(A_STATUS, d);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL reset_frame_count: got %08h expected 00000000", d); end
      rd(4'd2, d);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL reset_shadow: got %08h expected 00000000", d); end
      // preload the counter near its limit instead of spending 65536 frames
      force dut.frame_count_reg = 16'hFFFE;
      @(posedge clk_clk); #1;
      release dut.frame_count_reg;
      pulse_refresh();
      rd(A_STATUS, d);
      checks++;
      if (d !== 32'hFFFF_0000) begin errors++; $display("FAIL frame_count_max: got %08h expected ffff0000", d); end
      pulse_refresh();
      rd(A_STATUS, d);
      checks++;
      if (d !== 32'h0000_0000) begin errors++; $display("FAIL frame_count_wrap: got %08h expected 00000000", d); end
   endtask

   initial begin
      reset_reset          = 1'b1;
      avs_address          = '0;
      avs_write            = 1'b0;
      avs_writedata        = '0;
      avs_read             = 1'b0;
      refresh_image_export = 1'b0;
      test_reset();
      test_commit();
      test_no_commit();
      test_clamp();
      test_immediate();
      test_commit_on_tick();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
